mod_counter: RTL

Parametrised successor to the 4-bit enable/clear counter: a WIDTH-bit up/down counter with programmable top value, parallel load, wrap or saturate mode, and an enable prescaler. It sits wherever the design needs a tick/event counter or timer (cycle counters, timeouts, test-bench stimulus sequencing). All state is registered on `clk`. The only combinational output is `tc`.

---
 rtl/mod_counter.sv | 53 +++++
 1 files changed

// File: rtl/mod_counter.sv
// mod_counter: WIDTH-bit up/down counter with top value MAX, load, wrap/saturate modes and enable prescaler.
module mod_counter #(
  parameter int unsigned WIDTH = 4,
  parameter logic [WIDTH-1:0] MAX = '1,
  parameter int unsigned PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             up,
  input  logic             sat,
  output logic [WIDTH-1:0] cnt,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);
  localparam int unsigned PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PTOP = PW'(PRESCALE - 1);
  logic [PW-1:0] pre;
  logic last, lim;
  assign last = pre == PTOP;
  assign lim  = up ? cnt == MAX : cnt == '0;
  assign tc   = lim;
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt  <= '0;
      pre  <= '0;
      wrap <= 1'b0;
      ovf  <= 1'b0;
    end else if (load) begin
      cnt  <= din > MAX ? MAX : din;
      pre  <= '0;
      wrap <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (en) begin
        pre <= last ? '0 : pre + 1'b1;
        // a step at the limit either wraps to the opposite end or is blocked
        if (last) begin
          if (!lim) cnt <= up ? cnt + 1'b1 : cnt - 1'b1;
          else if (sat) ovf <= 1'b1;
          else begin
            cnt  <= up ? '0 : MAX;
            wrap <= 1'b1;
          end
        end
      end
    end
  end
endmodule
